// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states, datapath width and iteration count.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negate: dout = neg ? ~din + cin : din.
// The carry-in lets two instances chain into a double-width negate.
module muldiv_sign #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  input  logic             cin,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, cin}) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit (radix-2 shift-add multiply,
// restoring divide). Divide datapath present only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  import muldiv_pkg::*;

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   acc_hi_reg, acc_lo_reg, mcand_reg;
  logic               negq_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               div_zero_reg;

  op_e                op_in;
  logic               op_signed;
  logic               start_short;
  logic [WIDTH-1:0]   opnd     [2];
  logic [WIDTH-1:0]   opnd_mag [2];

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_neg_hi, fix_cin_hi;

`ifdef MULDIV_DIV_EN
  logic               is_div_reg;
  logic               negr_reg;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic               unused_div_msb;
`endif

  assign op_in     = op_e'(op);
  assign op_signed = op_is_signed(op_in);
  assign opnd[0]   = a;
  assign opnd[1]   = b;

  // Operand magnitudes for signed ops; unsigned ops pass straight through.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mag
      muldiv_sign #(.WIDTH(WIDTH)) u_mag (
        .din  (opnd[gi]),
        .neg  (op_signed & opnd[gi][WIDTH-1]),
        .cin  (1'b1),
        .dout (opnd_mag[gi])
      );
    end
  endgenerate

`ifdef MULDIV_DIV_EN
  assign start_short    = op_is_div(op_in) && (b == '0);
  assign unused_div_msb = div_diff[WIDTH];
`else
  assign start_short = op_is_div(op_in);
`endif

  // One iteration step; the final step feeds sign correction directly.
  always_comb begin
    mul_sum    = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, mcand_reg} : '0);
    step_hi    = mul_sum[WIDTH:1];
    step_lo    = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    fix_neg_hi = negq_reg;
    fix_cin_hi = (step_lo == '0);
`ifdef MULDIV_DIV_EN
    div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    div_ge    = (div_shift >= {1'b0, mcand_reg});
    if (is_div_reg) begin
      step_hi    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo    = {acc_lo_reg[WIDTH-2:0], div_ge};
      fix_neg_hi = negr_reg;
      fix_cin_hi = 1'b1;
    end
`endif
  end

  // Low word negates with carry-in 1; its zero-ness carries into the high word
  // for 64-bit products.
  muldiv_sign #(.WIDTH(WIDTH)) u_fix_lo (
    .din  (step_lo),
    .neg  (negq_reg),
    .cin  (1'b1),
    .dout (fix_lo)
  );

  muldiv_sign #(.WIDTH(WIDTH)) u_fix_hi (
    .din  (step_hi),
    .neg  (fix_neg_hi),
    .cin  (fix_cin_hi),
    .dout (fix_hi)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = start_short ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_reg == CNT_LAST) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      mcand_reg    <= '0;
      negq_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_reg   <= 1'b0;
      negr_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            acc_hi_reg <= '0;
            negq_reg   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            is_div_reg <= op_is_div(op_in);
            negr_reg   <= op_signed & a[WIDTH-1];
            if (op_is_div(op_in)) begin
              acc_lo_reg <= opnd_mag[0];
              mcand_reg  <= opnd_mag[1];
            end else begin
              acc_lo_reg <= opnd_mag[1];
              mcand_reg  <= opnd_mag[0];
            end
            if (start_short) begin
              hi_reg       <= a;
              lo_reg       <= '1;
              div_zero_reg <= 1'b1;
            end
`else
            acc_lo_reg <= opnd_mag[1];
            mcand_reg  <= opnd_mag[0];
            if (start_short) begin
              hi_reg       <= '0;
              lo_reg       <= '0;
              div_zero_reg <= 1'b0;
            end
`endif
          end
        end
        ST_RUN: begin
          acc_hi_reg <= step_hi;
          acc_lo_reg <= step_lo;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            hi_reg       <= fix_hi;
            lo_reg       <= fix_lo;
            div_zero_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] p;
    e.hi = '0; e.lo = '0; e.dz = 1'b0; e.lat = 33;
    sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
    sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
    if (!o[1]) begin
      p = 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (!DIV_EN) begin
      e.lat = 1;
    end else if (y == 32'd0) begin
      e.hi = x; e.lo = '1; e.dz = 1'b1; e.lat = 1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h dz=%b, want all zero", busy, done, hi, lo, div_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: busy=%b done=%b hi=%h lo=%h dz=%b", busy, done, hi, lo, div_zero);
  endtask

  task automatic test_vectors();
    vec_t v[$];
    exp_t e;
    int   n;
    bit   busy_bad;
    v.push_back('{"multu_max",  2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF});
    v.push_back('{"mult_neg",   2'd0, 32'hFFFFFFFD, 32'd5});
    v.push_back('{"mult_carry", 2'd0, 32'h00010000, 32'hFFFF0000});
    v.push_back('{"mult_min",   2'd0, 32'h80000000, 32'h80000000});
    v.push_back('{"div_neg",    2'd2, 32'hFFFFFFF9, 32'd2});
    v.push_back('{"div_negb",   2'd2, 32'd7,        32'hFFFFFFFE});
    v.push_back('{"divu_100_7", 2'd3, 32'd100,      32'd7});
    v.push_back('{"div_ovf",    2'd2, 32'h80000000, 32'hFFFFFFFF});
    v.push_back('{"divu_zero",  2'd3, 32'h00001234, 32'd0});
    v.push_back('{"multu_2x3",  2'd1, 32'd2,        32'd3});
    v.push_back('{"div_zero_s", 2'd2, 32'h80000001, 32'd0});
    v.push_back('{"divu_big",   2'd3, 32'hFFFFFFFF, 32'h80000000});
    for (int i = 0; i < 10; i++)
      v.push_back('{"random", 2'($urandom_range(0, 3)), 32'($urandom),
                    (i % 3 == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom)});

    foreach (v[i]) begin
      @(negedge clk);
      start = 1'b1; op = v[i].op; a = v[i].a; b = v[i].b;
      sb.push_back(model(v[i].op, v[i].a, v[i].b));
      @(negedge clk);
      start = 1'b0;
      n = 1;
      busy_bad = 1'b0;
      while (done !== 1'b1 && n < 40) begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        @(negedge clk);
        n++;
      end
      e = sb.pop_front();
      $display("%s: op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b done_at=k+%0d", v[i].name, v[i].op, v[i].a, v[i].b, hi, lo, div_zero, n);
      checks++;
      if (n != e.lat) begin
        errors++;
        $display("FAIL %s latency: got k+%0d, want k+%0d", v[i].name, n, e.lat);
      end
      checks++;
      if (busy_bad || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: dropped before done (busy at done=%b), want high k+1..k+%0d", v[i].name, busy, e.lat);
      end
      checks++;
      if (hi !== e.hi) begin
        errors++;
        $display("FAIL %s hi: got %h, want %h", v[i].name, hi, e.hi);
      end
      checks++;
      if (lo !== e.lo) begin
        errors++;
        $display("FAIL %s lo: got %h, want %h", v[i].name, lo, e.lo);
      end
      checks++;
      if (div_zero !== e.dz) begin
        errors++;
        $display("FAIL %s div_zero: got %b, want %b", v[i].name, div_zero, e.dz);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== e.hi || lo !== e.lo) begin
        errors++;
        $display("FAIL %s after_done: got busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h", v[i].name, busy, done, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n, dones, done_at;
    logic [31:0] cap_hi, cap_lo;
    cap_hi = 'x; cap_lo = 'x; dones = 0; done_at = -1;
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
    sb.push_back(model(2'd1, 32'd6, 32'd7));
    @(negedge clk);
    n = 1;
    repeat (33) begin
      if (done === 1'b1) begin
        dones++; done_at = n; cap_hi = hi; cap_lo = lo;
      end
      start = (n == 5) || (n == 33);
      if (n == 5)  begin op = 2'd3; a = 32'd99; b = 32'd0; end
      if (n == 33) begin op = 2'd1; a = 32'd3;  b = 32'd3; end
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    $display("ignore_start: 6*7 dones=%0d done_at=k+%0d lo=%h", dones, done_at, cap_lo);
    checks++;
    if (dones != 1 || done_at != e.lat) begin
      errors++;
      $display("FAIL ignore_start done: got %0d pulses at k+%0d, want 1 at k+%0d", dones, done_at, e.lat);
    end
    checks++;
    if (cap_hi !== e.hi || cap_lo !== e.lo) begin
      errors++;
      $display("FAIL ignore_start result: got hi=%h lo=%h, want hi=%h lo=%h", cap_hi, cap_lo, e.hi, e.lo);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back idle: busy at k+34 got %b, want 0", busy);
    end
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
    sb.push_back(model(2'd1, 32'd5, 32'd5));
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    $display("back_to_back: 5*5 done_at=k+%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n != e.lat || lo !== e.lo || hi !== e.hi) begin
      errors++;
      $display("FAIL back_to_back: got k+%0d hi=%h lo=%h, want k+%0d hi=%h lo=%h", n, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   n, dones;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'hFFFFFFFB; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset_abort: busy=%b done=%b hi=%h lo=%h dz=%b", busy, done, hi, lo, div_zero);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort async: got busy=%b done=%b hi=%h lo=%h dz=%b, want all zero", busy, done, hi, lo, div_zero);
    end
    dones = 0;
    for (n = 10; n < 45; n++) begin
      @(negedge clk);
      if (n == 12) rst_n = 1'b1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_abort done: got %0d pulses, want 0", dones);
    end
    start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd2;
    sb.push_back(model(2'd0, 32'd2, 32'd2));
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    $display("after_reset: 2*2 done_at=k+%0d hi=%h lo=%h", n, hi, lo);
    checks++;
    if (n != e.lat || lo !== e.lo || hi !== e.hi) begin
      errors++;
      $display("FAIL after_reset: got k+%0d hi=%h lo=%h, want k+%0d hi=%h lo=%h", n, hi, lo, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation; honoured only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have port a  input  32  multiplicand / dividend.
REQ-007 SHALL have port b  input  32  multiplier / divisor.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-009 SHALL have port done  output  1  one-cycle pulse; hi/lo/div_zero valid.
REQ-010 SHALL have port hi  output  32  product high word / remainder.
REQ-011 SHALL have port lo  output  32  product low word / quotient.
REQ-012 SHALL have port div_zero  output  1  last DIV/DIVU had b == 0; held with hi/lo.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 IDLE with start=1 SHALL register op, a and b, and enter RUN; start=1 in RUN or DONE SHALL be ignored with no side effects.
REQ-015 RUN SHALL last exactly 32 cycles, one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle, counted by a 5-bit counter that wraps 31->0 on exit.
REQ-016 Start sampled in cycle k SHALL give busy=1 in cycles k+1..k+33 and done=1 only in cycle k+33; the FSM SHALL be back in IDLE in k+34, so start may be accepted in k+34 at the earliest.
REQ-017 hi/lo/div_zero SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-018 MULT/DIV SHALL take operand magnitudes, run the unsigned core and sign-correct on DONE entry; MULTU/DIVU SHALL use raw operands.
REQ-019 MULT/MULTU SHALL give {hi,lo} = full 64-bit product.
REQ-020 DIV/DIVU SHALL truncate the quotient toward zero, and the remainder SHALL take the dividend's sign.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, div_zero=0.
REQ-022 DIV/DIVU with b == 0 SHALL go IDLE -> DONE directly, so done is high in cycle k+1; the result SHALL be hi=a, lo=0xFFFFFFFF, div_zero=1.
REQ-023 Multiplies SHALL clear div_zero.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0, independent of clk.
REQ-025 Reset during RUN/DONE SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined SHALL include the divide datapath and REQ-020..REQ-022.
REQ-027 Without MULDIV_DIV_EN, op 2/3 SHALL go IDLE -> DONE in one cycle with hi=0, lo=0, div_zero=0, no divider logic synthesized, multiply behaviour and latency unchanged.

Structure
REQ-028 Package muldiv_pkg SHALL hold the op encodings, the FSM state enum, WIDTH=32 and the iteration count (32).
REQ-029 SHALL instantiate one combinational sub-module muldiv_sign (abs / conditional two's-complement negate, 32-bit) for operand magnitude and result correction.

Verification
REQ-030 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at k+33, hi=0xFFFFFFFE, lo=0x00000001, busy high k+1..k+33.
REQ-031 MULT a=-3 b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIVU a=100 b=7 -> lo=14, hi=2, div_zero=0; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU a=0x1234 b=0 -> done at k+1, hi=0x1234, lo=0xFFFFFFFF, div_zero=1; following MULTU 2*3 -> lo=6, div_zero=0.
REQ-034 start pulsed with new operands at k+5 and k+33 during MULTU 6*7 -> single done at k+33, lo=42; start at k+34 accepted.
REQ-035 rst_n low at k+10 of a MULT -> outputs zero asynchronously, no done pulse; the next MULT 2*2 completes normally with lo=4.
